// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

  localparam int          XLEN_DEFAULT     = 32;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [XLEN_DEFAULT-1:0] instr;
  } if_entry_t;

  // Number of bits needed to index 'value' entries (ceil(log2)).
  function automatic int log2_ceil(input int value);
    int width;
    width = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) width = i + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/if_fetch_fifo.sv
// Synchronous FIFO of DEPTH entries with flush; head is read straight from the storage registers.
module if_fetch_fifo
  import if_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = if_entry_t
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  entry_t                   push_data,
  input  logic                     pop,
  input  logic                     flush,
  output entry_t                   head,
  output logic [log2_ceil(DEPTH):0] count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = log2_ceil(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage: credit-limited imem requests feed a prefetch queue toward decode.
// Optional macro IF_PERF_CNT_EN adds perf_fetch_cnt / perf_flush_cnt outputs.
module if_prefetch_stage
  import if_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pc_src,
  input  logic [XLEN-1:0] pc_branch,
  input  logic            id_ready,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            if_valid,
  output logic [XLEN-1:0] PC_IF,
  output logic [XLEN-1:0] INSTRUCTION_IF
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_flush_cnt
`endif
);

  localparam int CNT_W  = log2_ceil(DEPTH) + 1;
  localparam int DROP_W = log2_ceil(2 * DEPTH) + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  // The request-PC FIFO only needs the PC of each outstanding request.
  typedef struct packed {
    logic [XLEN-1:0] pc;
  } req_entry_t;

  logic [XLEN-1:0]   fetch_pc;
  logic              req_en;
  logic [DROP_W-1:0] drop_cnt;
  logic [CNT_W:0]    credits_used;
  logic              req_fire;
  logic              rsp_drop;
  logic              rsp_take;

  entry_t            q_head;
  entry_t            q_push_data;
  logic              q_push;
  logic [CNT_W-1:0]  q_count;
  logic              q_full;
  logic              q_empty;

  req_entry_t        pcq_head;
  req_entry_t        pcq_push_data;
  logic [CNT_W-1:0]  pcq_count;
  logic              pcq_full;
  logic              pcq_empty;

  // Queued plus in-flight entries never exceed DEPTH, so every response has a slot.
  assign credits_used   = {1'b0, q_count} + {1'b0, pcq_count};
  assign imem_req_valid = req_en && !pc_src && !pcq_full
                          && (credits_used < (CNT_W + 1)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_drop       = imem_rsp_valid && (drop_cnt != '0);
  assign rsp_take       = imem_rsp_valid && (drop_cnt == '0) && !pcq_empty;
  assign q_push         = rsp_take && !pc_src && (!q_full || id_ready);

  assign pcq_push_data  = '{pc: fetch_pc};
  assign q_push_data    = '{pc: pcq_head.pc, instr: imem_rsp_data};

  if_fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (req_entry_t)
  ) u_req_pc_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (req_fire),
    .push_data (pcq_push_data),
    .pop       (rsp_take),
    .flush     (pc_src),
    .head      (pcq_head),
    .count     (pcq_count),
    .full      (pcq_full),
    .empty     (pcq_empty)
  );

  if_fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_prefetch_queue (
    .clk       (clk),
    .reset     (reset),
    .push      (q_push),
    .push_data (q_push_data),
    .pop       (id_ready),
    .flush     (pc_src),
    .head      (q_head),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  assign if_valid       = !q_empty;
  assign PC_IF          = q_empty ? '0 : q_head.pc;
  assign INSTRUCTION_IF = q_empty ? XLEN'(NOP_INSTR) : q_head.instr;

  // On redirect every in-flight request becomes a response to discard; a response
  // arriving in the redirect cycle itself is already accounted for.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      req_en   <= 1'b0;
      drop_cnt <= '0;
    end else begin
      req_en <= 1'b1;
      if (pc_src) begin
        fetch_pc <= pc_branch & ~XLEN'(3);
        drop_cnt <= drop_cnt + DROP_W'(pcq_count) - DROP_W'(imem_rsp_valid);
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
        if (rsp_drop) drop_cnt <= drop_cnt - DROP_W'(1);
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetch_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (q_push) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (pc_src) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

  a_rsp_legal: assert property (@(posedge clk) disable iff (!reset)
    imem_rsp_valid |-> (pcq_count != '0 || drop_cnt != '0));

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Directed self-checking bench for if_prefetch_stage with a variable-latency in-order memory model.
module tb_if_prefetch_stage;

  logic        clk;
  logic        reset;
  logic        pc_src;
  logic [31:0] pc_branch;
  logic        id_ready;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic [31:0] PC_IF;
  logic [31:0] INSTRUCTION_IF;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int mem_lat = 1;
  int cyc_cnt;
  int req_count;

  typedef struct {
    int          due;
    logic [31:0] addr;
  } pend_t;
  pend_t pending[$];

  if_prefetch_stage #(
    .XLEN     (32),
    .DEPTH    (4),
    .RESET_PC (32'h0)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .pc_src         (pc_src),
    .pc_branch      (pc_branch),
    .id_ready       (id_ready),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .PC_IF          (PC_IF),
    .INSTRUCTION_IF (INSTRUCTION_IF)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instrOf(input logic [31:0] addr);
    return 32'hA500_0000 ^ addr;
  endfunction

  // In-order memory: a request accepted at edge c answers during the cycle after edge c+mem_lat-1.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending.delete();
      imem_rsp_valid <= 1'b0;
      imem_rsp_data  <= '0;
      cyc_cnt        <= 0;
      req_count      <= 0;
    end else begin
      cyc_cnt <= cyc_cnt + 1;
      if (imem_req_valid && imem_req_ready) begin
        pending.push_back('{due: cyc_cnt + mem_lat - 1, addr: imem_req_addr});
        req_count <= req_count + 1;
      end
      if (pending.size() > 0 && pending[0].due <= cyc_cnt) begin
        imem_rsp_valid <= 1'b1;
        imem_rsp_data  <= instrOf(pending[0].addr);
        void'(pending.pop_front());
      end else begin
        imem_rsp_valid <= 1'b0;
        imem_rsp_data  <= '0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkHead(input string tag, input logic [31:0] pc);
    checkOutput({tag, "_valid"}, 32'(if_valid), 32'd1);
    checkOutput({tag, "_pc"}, PC_IF, pc);
    checkOutput({tag, "_instr"}, INSTRUCTION_IF, instrOf(pc));
  endtask

  // Drives one cycle of inputs; a redirect is a one-cycle pulse unless re-applied.
  task automatic applyStimulus(input logic src, input logic [31:0] target, input logic ready);
    pc_src    = src;
    pc_branch = target;
    id_ready  = ready;
    @(posedge clk);
    #1 pc_src = 1'b0;
    @(negedge clk);
  endtask

  task automatic resetDut(input int lat);
    reset     = 1'b0;
    pc_src    = 1'b0;
    pc_branch = '0;
    id_ready  = 1'b1;
    mem_lat   = lat;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic waitValid(input string tag, input int budget, input int expected_waits);
    int waited;
    waited = 0;
    while (if_valid !== 1'b1 && waited < budget) begin
      applyStimulus(1'b0, 32'h0, 1'b1);
      waited++;
    end
    checkOutput(tag, 32'(waited), 32'(expected_waits));
  endtask

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: observed timeout required completion");
    $fatal(1, "[TB] simulation timed out");
  end

  initial begin
    $display("[TB] if_prefetch_stage directed tests");
    imem_req_ready = 1'b1;
    pc_src         = 1'b0;
    pc_branch      = '0;
    id_ready       = 1'b1;
    mem_lat        = 1;
    reset          = 1'b0;

    // Test 1: reset values, then streaming with 1-cycle memory
    repeat (2) @(negedge clk);
    checkOutput("rst_if_valid", 32'(if_valid), 32'd0);
    checkOutput("rst_pc_if", PC_IF, 32'h0);
    checkOutput("rst_instr_if", INSTRUCTION_IF, 32'h0000_0013);
    checkOutput("rst_req_valid", 32'(imem_req_valid), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("t1_c1_req_valid", 32'(imem_req_valid), 32'd1);
    checkOutput("t1_c1_req_addr", imem_req_addr, 32'h0);
    checkOutput("t1_c1_if_valid", 32'(if_valid), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("t1_c2_if_valid", 32'(if_valid), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkHead("t1_c3", 32'h0);
    for (int i = 1; i < 4; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkHead($sformatf("t1_c%0d", i + 3), 32'(4 * i));
    end

    // Test 2: decode stall fills the queue, then drains in order
    resetDut(1);
    repeat (10) applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("t2_req_count", 32'(req_count), 32'd4);
    checkOutput("t2_req_valid", 32'(imem_req_valid), 32'd0);
    checkHead("t2_hold", 32'h0);
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b1);
      checkHead($sformatf("t2_drain%0d", i), 32'(4 * i));
    end

    // Test 3: redirect to 0x100 with two requests in flight, latency 3
    resetDut(3);
    applyStimulus(1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("t3_pre_addr", imem_req_addr, 32'h8);
    applyStimulus(1'b1, 32'h100, 1'b1);
    checkOutput("t3_flush_if_valid", 32'(if_valid), 32'd0);
    checkOutput("t3_req_valid", 32'(imem_req_valid), 32'd1);
    checkOutput("t3_req_addr", imem_req_addr, 32'h100);
    waitValid("t3_wait", 12, 4);
    checkHead("t3_first", 32'h100);
`ifdef IF_PERF_CNT_EN
    checkOutput("t3_perf_flush", perf_flush_cnt, 32'd1);
    checkOutput("t3_perf_fetch", perf_fetch_cnt, 32'd1);
`endif
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkHead("t3_second", 32'h104);

    // Test 4: misaligned redirect target is word-aligned
    resetDut(1);
    applyStimulus(1'b1, 32'h203, 1'b1);
    checkOutput("t4_req_valid", 32'(imem_req_valid), 32'd1);
    checkOutput("t4_req_addr", imem_req_addr, 32'h200);
    applyStimulus(1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkHead("t4_head", 32'h200);

    // Test 5: back-to-back redirects, later target wins
    resetDut(3);
    applyStimulus(1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    applyStimulus(1'b1, 32'h40, 1'b1);
    applyStimulus(1'b1, 32'h80, 1'b1);
    checkOutput("t5_req_addr", imem_req_addr, 32'h80);
    checkOutput("t5_if_valid", 32'(if_valid), 32'd0);
    waitValid("t5_wait", 12, 4);
    checkHead("t5_first", 32'h80);
`ifdef IF_PERF_CNT_EN
    checkOutput("t5_perf_flush", perf_flush_cnt, 32'd2);
    checkOutput("t5_perf_fetch", perf_fetch_cnt, 32'd1);
`endif
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkHead("t5_second", 32'h84);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkHead("t5_third", 32'h88);

    // Test 6: asynchronous reset with a full queue
    resetDut(1);
    repeat (8) applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("t6_full_valid", 32'(if_valid), 32'd1);
    checkOutput("t6_full_req_valid", 32'(imem_req_valid), 32'd0);
    #2 reset = 1'b0;
    #1;
    checkOutput("t6_rst_if_valid", 32'(if_valid), 32'd0);
    checkOutput("t6_rst_req_valid", 32'(imem_req_valid), 32'd0);
    checkOutput("t6_rst_pc_if", PC_IF, 32'h0);
    checkOutput("t6_rst_instr_if", INSTRUCTION_IF, 32'h0000_0013);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("t6_restart_addr", imem_req_addr, 32'h0);
    checkOutput("t6_restart_valid", 32'(imem_req_valid), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkHead("t6_head", 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
